// File: rtl/upscale_2x_stage.sv
// rtl/upscale_2x_stage.sv - 2x nearest-neighbour upscaler between a pixel FIFO and a valid/ready sink
//
// Each input line is emitted twice (FILL from the FIFO, REPEAT from a line
// buffer), and every pixel within a line is emitted twice, so an
// IN_WIDTH x IN_HEIGHT frame becomes 2*IN_WIDTH x 2*IN_HEIGHT.
//
// Ports:
//   clk_r        in   1   sole clock (FIFO read clock), rising edge
//   rst          in   1   synchronous active-high reset
//   din          in  17   FIFO read data, [16]=SOF, [15:0]=RGB565, valid the cycle after rd_fifo
//   data_count_r in  10   FIFO read-side occupancy
//   rd_fifo      out  1   FIFO pop strobe
//   dout         out 17   output pixel, [16]=SOF on first copy of pixel (0,0)
//   dout_valid   out  1   output valid
//   dout_ready   in   1   output ready; transfer when dout_valid & dout_ready
//   frame_done   out  1   one-cycle pulse after the last output pixel of a frame
//   sync_err     out  1   one-cycle pulse on SOF resync
//
// Optional: define UPSCALE_SOF_SYNC_EN to resynchronise on an input SOF
// seen anywhere other than pixel (0,0); otherwise din[16] is ignored and
// sync_err is tied low.

module upscale_2x_stage #(
    parameter int IN_WIDTH  = 320,
    parameter int IN_HEIGHT = 240
) (
    input  logic        clk_r,
    input  logic        rst,
    input  logic [16:0] din,
    input  logic [9:0]  data_count_r,
    output logic        rd_fifo,
    output logic [16:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        frame_done,
    output logic        sync_err
);
    localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, REPEAT} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [15:0]   r_lbuf [IN_WIDTH];
    logic          r_din_vld;
    logic          r_hold_full;
    logic [15:0]   r_hold_data;
    logic          r_out_valid;
    logic [15:0]   r_out_data;
    logic          r_out_sof;
    logic          r_out_eol;
    logic          r_out_eof;
    logic          r_copy;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_src_rep;
    logic          r_frame_done;
    logic          r_sync_err;

    logic          w_xfer;
    logic          w_pair_done;
    logic          w_out_free;
    logic          w_resync;
    logic [CW-1:0] w_ld_col;
    logic [RW-1:0] w_ld_row;
    logic          w_ld_rep;
    logic          w_load;
    logic          w_ld_from_fifo;
    logic [15:0]   w_ld_data;
    logic          w_ld_eol;
    logic          w_ld_eof;
    logic          w_ld_sof;

    assign w_xfer      = r_out_valid & dout_ready;
    assign w_pair_done = w_xfer & r_copy;
    assign w_out_free  = ~r_out_valid | w_pair_done;

`ifdef UPSCALE_SOF_SYNC_EN
    // A word on din always lands on the next load position: (r_col, r_row)
    // while filling, or column 0 of the following row when it is a prefetch
    // made while the current line is being replayed.
    logic w_din_at_origin;
    assign w_din_at_origin = r_src_rep ? (r_row == ROW_LAST)
                                       : ((r_col == '0) && (r_row == '0));
    assign w_resync = r_din_vld & din[16] & ~w_din_at_origin;
`else
    logic w_unused_sof;
    assign w_unused_sof = din[16];
    assign w_resync     = 1'b0;
`endif

    // Resync re-labels the arriving word as pixel (0,0) of a fresh FILL line.
    assign w_ld_col = w_resync ? '0   : r_col;
    assign w_ld_row = w_resync ? '0   : r_row;
    assign w_ld_rep = w_resync ? 1'b0 : r_src_rep;

    // A word arriving on din only ever meets an empty holding register, so
    // it may bypass straight into the output register to keep one output
    // per clock across line turnarounds.
    assign w_load         = w_out_free & (w_ld_rep | r_hold_full | r_din_vld);
    assign w_ld_from_fifo = w_load & ~w_ld_rep;
    assign w_ld_data      = w_ld_rep    ? r_lbuf[w_ld_col] :
                            r_hold_full ? r_hold_data      : din[15:0];
    assign w_ld_eol       = (w_ld_col == COL_LAST);
    assign w_ld_eof       = w_ld_rep & w_ld_eol & (w_ld_row == ROW_LAST);
    assign w_ld_sof       = ~w_ld_rep & (w_ld_col == '0) & (w_ld_row == '0);

    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The state tracks the phase of the pixel pair currently on dout; it
    // advances on the final transfer of each line.
    always_comb begin
        w_state_next = r_state;
        rd_fifo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_count_r != 10'd0) w_state_next = FILL;
            end
            FILL: begin
                if ((data_count_r != 10'd0) && !r_din_vld &&
                    (!r_hold_full || w_ld_from_fifo))
                    rd_fifo = 1'b1;
                if (w_pair_done && r_out_eol) w_state_next = REPEAT;
            end
            REPEAT: begin
                if (w_pair_done && r_out_eol) w_state_next = FILL;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_resync) w_state_next = FILL;
        if (rst)      rd_fifo      = 1'b0;
    end

    always_ff @(posedge clk_r) begin
        if (rst) begin
            r_din_vld    <= 1'b0;
            r_hold_full  <= 1'b0;
            r_hold_data  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sof    <= 1'b0;
            r_out_eol    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_copy       <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_src_rep    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_din_vld    <= rd_fifo;
            r_hold_full  <= (r_hold_full | r_din_vld) & ~w_ld_from_fifo;
            if (r_din_vld) r_hold_data <= din[15:0];

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ld_data;
                r_out_sof   <= w_ld_sof;
                r_out_eol   <= w_ld_eol;
                r_out_eof   <= w_ld_eof;
                r_copy      <= 1'b0;
                r_col       <= w_ld_eol ? '0 : w_ld_col + 1'b1;
                r_src_rep   <= w_ld_eol ? ~w_ld_rep : w_ld_rep;
                if (w_ld_eol && w_ld_rep)
                    r_row <= (w_ld_row == ROW_LAST) ? '0 : w_ld_row + 1'b1;
                else
                    r_row <= w_ld_row;
            end else begin
                if (w_xfer) begin
                    r_copy <= ~r_copy;
                    if (r_copy) r_out_valid <= 1'b0;
                end
                // A resync abandons the line in flight, so the pair still
                // draining must not trigger a line or frame turnaround.
                if (w_resync) begin
                    r_out_eol <= 1'b0;
                    r_out_eof <= 1'b0;
                end
                r_col     <= w_ld_col;
                r_row     <= w_ld_row;
                r_src_rep <= w_ld_rep;
            end

            r_frame_done <= w_pair_done & r_out_eof;
            r_sync_err   <= w_resync;
        end
    end

    always_ff @(posedge clk_r) begin
        if (!rst && w_ld_from_fifo) r_lbuf[w_ld_col] <= w_ld_data;
    end

    assign dout       = {r_out_sof & ~r_copy, r_out_data};
    assign dout_valid = r_out_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_upscale_2x_stage.sv
// tb/tb_upscale_2x_stage.sv - scoreboard bench for upscale_2x_stage
module tb_upscale_2x_stage;
    localparam int W = 4;
    localparam int H = 2;

    logic        clk_r = 1'b0;
    logic        rst;
    logic [16:0] din = '0;
    logic [9:0]  data_count_r = '0;
    logic        rd_fifo;
    logic [16:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        frame_done;
    logic        sync_err;

    upscale_2x_stage #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .clk_r        (clk_r),
        .rst          (rst),
        .din          (din),
        .data_count_r (data_count_r),
        .rd_fifo      (rd_fifo),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .frame_done   (frame_done),
        .sync_err     (sync_err)
    );

    always #5 clk_r = ~clk_r;

    logic [16:0] fifo_q [$];
    logic [16:0] exp_q  [$];
    logic        cnt_zero = 1'b0;
    int n_pops = 0, bad_pop = 0, pop_base = 0;
    int n_xfer = 0, n_fd = 0, n_serr = 0;
    int n_pass = 0, n_total = 0;

    logic [16:0] frame_in [8] = '{17'h10001, 17'h00002, 17'h00003, 17'h00004,
                                  17'h00005, 17'h00006, 17'h00007, 17'h00008};
    logic [16:0] exp_frame [32] = '{
        17'h10001, 17'h00001, 17'h00002, 17'h00002, 17'h00003, 17'h00003, 17'h00004, 17'h00004,
        17'h00001, 17'h00001, 17'h00002, 17'h00002, 17'h00003, 17'h00003, 17'h00004, 17'h00004,
        17'h00005, 17'h00005, 17'h00006, 17'h00006, 17'h00007, 17'h00007, 17'h00008, 17'h00008,
        17'h00005, 17'h00005, 17'h00006, 17'h00006, 17'h00007, 17'h00007, 17'h00008, 17'h00008};
    logic [16:0] sof_in [4] = '{17'h10001, 17'h00002, 17'h1000A, 17'h0000B};
`ifdef UPSCALE_SOF_SYNC_EN
    localparam int SOF_N = 8;
    localparam int SOF_SERR = 1;
    logic [16:0] exp_sof [SOF_N] = '{17'h10001, 17'h00001, 17'h00002, 17'h00002,
                                     17'h1000A, 17'h0000A, 17'h0000B, 17'h0000B};
`else
    localparam int SOF_N = 16;
    localparam int SOF_SERR = 0;
    logic [16:0] exp_sof [SOF_N] = '{17'h10001, 17'h00001, 17'h00002, 17'h00002,
                                     17'h0000A, 17'h0000A, 17'h0000B, 17'h0000B,
                                     17'h00001, 17'h00001, 17'h00002, 17'h00002,
                                     17'h0000A, 17'h0000A, 17'h0000B, 17'h0000B};
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // FIFO model: pops on rd_fifo, data valid the following cycle.
    always @(posedge clk_r) begin
        if (rd_fifo) begin
            if (data_count_r == 10'd0) bad_pop++;
            if (fifo_q.size() != 0) begin
                din <= fifo_q.pop_front();
                n_pops++;
            end
        end
    end

    always @(negedge clk_r)
        data_count_r <= cnt_zero ? 10'd0 : 10'(fifo_q.size());

    // Monitor: compares every output transfer against the scoreboard.
    always @(negedge clk_r) begin
        if (!rst) begin
            if (frame_done) begin
                n_fd++;
                chk("frame_done_pos", n_xfer, 32);
            end
            if (sync_err) n_serr++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_output: got 0x%05h, nothing expected", dout);
                end else begin
                    chk($sformatf("dout[%0d]", n_xfer), 32'(dout), 32'(exp_q.pop_front()));
                end
                n_xfer++;
            end
        end
    end

    task automatic step();
        @(posedge clk_r);
        #1;
    endtask

    task automatic start_test();
        n_xfer = 0; n_fd = 0; n_serr = 0; pop_base = n_pops;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 8; i++) fifo_q.push_back(frame_in[i]);
        for (int i = 0; i < 32; i++) exp_q.push_back(exp_frame[i]);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL %s_timeout: %0d outputs outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (6) step();
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_rd_fifo"},    rd_fifo,    0);
        chk({name, "_dout"},       dout,       0);
        chk({name, "_dout_valid"}, dout_valid, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_sync_err"},   sync_err,   0);
    endtask

    initial begin
        int k;
        rst = 1'b1; dout_ready = 1'b1; cnt_zero = 1'b0;
        repeat (3) step();
        reset_checks("rst0");
        rst = 1'b0;

        // Plain frame
        start_test(); push_frame();
        wait_drain("frame_a", 400);
        chk("a_xfer", n_xfer, 32); chk("a_fd", n_fd, 1);

        // Backpressure on 0x0003
        start_test(); push_frame();
        k = 0;
        while (!(dout_valid && dout == 17'h00003) && k < 200) begin step(); k++; end
        chk("b_found3", 32'(dout_valid && dout == 17'h00003), 1);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_stall_dout", dout, 17'h00003);
            chk("b_stall_valid", dout_valid, 1);
        end
        dout_ready = 1'b1;
        wait_drain("frame_b", 400);
        chk("b_xfer", n_xfer, 32); chk("b_fd", n_fd, 1);

        // FIFO empties after two pops
        start_test(); push_frame();
        k = 0;
        while ((n_pops - pop_base) < 2 && k < 100) begin step(); k++; end
        chk("c_two_pops", n_pops - pop_base, 2);
        cnt_zero = 1'b1;
        repeat (12) step();
        chk("c_valid_low", dout_valid, 0);
        chk("c_xfer_held", n_xfer, 4);
        chk("c_rd_low", rd_fifo, 0);
        cnt_zero = 1'b0;
        wait_drain("frame_c", 400);
        chk("c_xfer", n_xfer, 32); chk("c_fd", n_fd, 1);

        // Reset during REPEAT, then a clean frame
        start_test(); push_frame();
        k = 0;
        while (n_xfer < 10 && k < 200) begin step(); k++; end
        chk("d_reached_repeat", 32'(n_xfer >= 10), 1);
        rst = 1'b1;
        step();
        reset_checks("rst_mid");
        exp_q.delete(); fifo_q.delete();
        rst = 1'b0;
        repeat (3) step();
        chk("d_idle_valid", dout_valid, 0);
        start_test(); push_frame();
        wait_drain("frame_d", 400);
        chk("d_xfer", n_xfer, 32); chk("d_fd", n_fd, 1);

        // Stray SOF at column 2
        start_test();
        for (int i = 0; i < 4; i++) fifo_q.push_back(sof_in[i]);
        for (int i = 0; i < SOF_N; i++) exp_q.push_back(exp_sof[i]);
        wait_drain("sof", 200);
        repeat (20) step();
        chk("e_xfer", n_xfer, SOF_N);
        chk("e_sync_err", n_serr, SOF_SERR);
        chk("e_fd", n_fd, 0);

        chk("no_bad_pop", bad_pop, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
